// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// (I) and a data requester (D). D has priority except when I has waited
// through STARVE_LIMIT consecutive D grants. A memory access that stays busy
// for MEM_TIMEOUT sampled cycles is aborted and flagged on bus_err.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   i_req/i_address       fetch request (held until i_valid) and word address
//   i_flush               redirect: discards the requested or outstanding fetch
//   i_valid/i_data_out    one-cycle fetch completion pulse and fetched word
//   d_req/d_rw            data request (held until d_valid), 1=read 0=write
//   d_address/d_data_in   data address and store data
//   d_access_size         size code passed through to the memory
//   d_valid/d_data_out    one-cycle data completion pulse and load data
//   stall_f/stall_m       combinational stall levels for the two requesters
//   mem_*                 registered shared memory port
//   mem_data_out/mem_busy memory read data and busy
//   bus_err               sticky timeout flag
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MEM_TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_address,
    input  logic        i_flush,
    output logic        i_valid,
    output logic [31:0] i_data_out,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_address,
    input  logic [31:0] d_data_in,
    input  logic [1:0]  d_access_size,
    output logic        d_valid,
    output logic [31:0] d_data_out,
    output logic        stall_f,
    output logic        stall_m,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    output logic        mem_rw,
    output logic        mem_enable,
    input  logic [31:0] mem_data_out,
    input  logic        mem_busy,
    output logic        bus_err
);

    localparam int unsigned SW = 3;
    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_mem_address;
    logic [31:0]     r_mem_data_in;
    logic [1:0]      r_mem_access_size;
    logic            r_mem_rw;
    logic            r_mem_enable;
    logic            r_i_valid;
    logic [31:0]     r_i_data_out;
    logic            r_d_valid;
    logic [31:0]     r_d_data_out;
    logic            r_bus_err;
    logic [SW-1:0]   r_streak;
    logic [TW-1:0]   r_timeout;
    logic            r_first;   // grant just issued: busy not yet meaningful
    logic            r_done;    // completion cycle: no grant allowed
    logic            r_drop;    // outstanding fetch was flushed

    logic            w_i_elig;
    logic            w_force_i;
    logic            w_tmo_hit;
    logic            w_drop;
    logic [SW-1:0]   w_streak_inc;
    logic            w_grant_i;
    logic            w_grant_d;
    logic            w_sample;
    logic            w_finish;
    logic            w_abort;

    assign w_i_elig     = i_req & ~i_flush;
    assign w_force_i    = w_i_elig & (r_streak == SW'(STARVE_LIMIT));
    assign w_tmo_hit    = (r_timeout == TW'(MEM_TIMEOUT - 1));
    assign w_drop       = r_drop | i_flush;
    assign w_streak_inc = (r_streak == SW'(STARVE_LIMIT)) ? r_streak : r_streak + SW'(1);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, arbitration and completion strobes
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_sample    = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_done) begin
                    if (d_req && !w_force_i) begin
                        w_grant_d   = 1'b1;
                        w_state_nxt = ST_WAIT_D;
                    end else if (w_i_elig) begin
                        w_grant_i   = 1'b1;
                        w_state_nxt = ST_WAIT_I;
                    end
                end
            end
            ST_WAIT_I, ST_WAIT_D: begin
                w_sample = ~r_first;
                if (w_sample) begin
                    if (!mem_busy) begin
                        w_finish = 1'b1;
                    end else if (w_tmo_hit) begin
                        w_abort = 1'b1;
                    end
                end
                if (w_finish || w_abort) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory port, completion outputs, starvation and timeout bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_address     <= '0;
            r_mem_data_in     <= '0;
            r_mem_access_size <= '0;
            r_mem_rw          <= 1'b1;
            r_mem_enable      <= 1'b0;
            r_i_valid         <= 1'b0;
            r_i_data_out      <= '0;
            r_d_valid         <= 1'b0;
            r_d_data_out      <= '0;
            r_bus_err         <= 1'b0;
            r_streak          <= '0;
            r_timeout         <= '0;
            r_first           <= 1'b0;
            r_done            <= 1'b0;
            r_drop            <= 1'b0;
        end else begin
            r_mem_enable <= w_grant_i | w_grant_d;
            r_first      <= w_grant_i | w_grant_d;
            r_done       <= w_finish | w_abort;
            r_i_valid    <= 1'b0;
            r_d_valid    <= 1'b0;

            if (w_grant_d) begin
                r_mem_address     <= d_address;
                r_mem_data_in     <= d_data_in;
                r_mem_access_size <= d_access_size;
                r_mem_rw          <= d_rw;
                r_streak          <= i_req ? w_streak_inc : '0;
            end
            if (w_grant_i) begin
                r_mem_address     <= i_address;
                r_mem_access_size <= 2'b00;
                r_mem_rw          <= 1'b1;
                r_streak          <= '0;
            end

            if (w_grant_i || w_grant_d) begin
                r_timeout <= '0;
                r_drop    <= 1'b0;
            end else if (w_sample && mem_busy && !w_abort) begin
                r_timeout <= r_timeout + TW'(1);
            end

            if (r_state == ST_WAIT_I && i_flush) begin
                r_drop <= 1'b1;
            end

            // Aborted accesses complete with zero data; a dropped fetch stays silent
            if (w_finish || w_abort) begin
                if (r_state == ST_WAIT_D) begin
                    r_d_valid <= 1'b1;
                    if (w_abort) begin
                        r_d_data_out <= '0;
                    end else if (r_mem_rw) begin
                        r_d_data_out <= mem_data_out;
                    end
                end else if (!w_drop) begin
                    r_i_valid    <= 1'b1;
                    r_i_data_out <= w_abort ? 32'h0 : mem_data_out;
                end
            end

            if (w_abort) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign mem_address     = r_mem_address;
    assign mem_data_in     = r_mem_data_in;
    assign mem_access_size = r_mem_access_size;
    assign mem_rw          = r_mem_rw;
    assign mem_enable      = r_mem_enable;
    assign i_valid         = r_i_valid;
    assign i_data_out      = r_i_data_out;
    assign d_valid         = r_d_valid;
    assign d_data_out      = r_d_data_out;
    assign bus_err         = r_bus_err;
    assign stall_f         = i_req & ~r_i_valid;
    assign stall_m         = d_req & ~r_d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int STARVE = 4;
    localparam int TMO    = 16;

    logic        clock;
    logic        reset;
    logic        i_req;
    logic [31:0] i_address;
    logic        i_flush;
    logic        i_valid;
    logic [31:0] i_data_out;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_address;
    logic [31:0] d_data_in;
    logic [1:0]  d_access_size;
    logic        d_valid;
    logic [31:0] d_data_out;
    logic        stall_f;
    logic        stall_m;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic [31:0] mem_data_out;
    logic        mem_busy;
    logic        bus_err;

    int n_total = 0;
    int n_bad   = 0;

    mem_arbiter #(.STARVE_LIMIT(STARVE), .MEM_TIMEOUT(TMO)) dut (
        .clock           (clock),
        .reset           (reset),
        .i_req           (i_req),
        .i_address       (i_address),
        .i_flush         (i_flush),
        .i_valid         (i_valid),
        .i_data_out      (i_data_out),
        .d_req           (d_req),
        .d_rw            (d_rw),
        .d_address       (d_address),
        .d_data_in       (d_data_in),
        .d_access_size   (d_access_size),
        .d_valid         (d_valid),
        .d_data_out      (d_data_out),
        .stall_f         (stall_f),
        .stall_m         (stall_m),
        .mem_address     (mem_address),
        .mem_data_in     (mem_data_in),
        .mem_access_size (mem_access_size),
        .mem_rw          (mem_rw),
        .mem_enable      (mem_enable),
        .mem_data_out    (mem_data_out),
        .mem_busy        (mem_busy),
        .bus_err         (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: one access at a time, tracked by owner and edges since grant
    int          m_owner = 0;     // 0 none, 1 fetch, 2 data
    int          m_age = 0;
    int          m_busy_cnt = 0;
    int          m_streak = 0;
    bit          m_cool = 0;
    bit          m_drop = 0;
    bit          m_i_ok;
    bit          m_abort;
    logic [31:0] e_addr = 0, e_wdata = 0, e_idata = 0, e_ddata = 0;
    logic [1:0]  e_size = 0;
    logic        e_rw = 1, e_en = 0, e_iv = 0, e_dv = 0, e_err = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_owner = 0; m_age = 0; m_busy_cnt = 0; m_streak = 0; m_cool = 0; m_drop = 0;
            e_addr = 0; e_wdata = 0; e_size = 0; e_rw = 1; e_en = 0;
            e_iv = 0; e_dv = 0; e_idata = 0; e_ddata = 0; e_err = 0;
        end else begin
            e_en = 0; e_iv = 0; e_dv = 0;
            if (m_owner == 0) begin
                if (m_cool) begin
                    m_cool = 0;
                end else begin
                    m_i_ok = i_req && !i_flush;
                    if (d_req && !(m_i_ok && m_streak == STARVE)) begin
                        m_owner = 2;
                        e_addr = d_address; e_wdata = d_data_in; e_size = d_access_size; e_rw = d_rw;
                        if (i_req) m_streak = (m_streak < STARVE) ? m_streak + 1 : STARVE;
                        else m_streak = 0;
                    end else if (m_i_ok) begin
                        m_owner = 1;
                        e_addr = i_address; e_size = 2'b00; e_rw = 1;
                        m_streak = 0;
                    end
                    if (m_owner != 0) begin
                        e_en = 1; m_age = 0; m_busy_cnt = 0; m_drop = 0;
                    end
                end
            end else begin
                m_age++;
                if (m_owner == 1 && i_flush) m_drop = 1;
                if (m_age >= 2) begin
                    m_abort = 0;
                    if (mem_busy) begin
                        m_busy_cnt++;
                        m_abort = (m_busy_cnt == TMO);
                    end
                    if (!mem_busy || m_abort) begin
                        if (m_owner == 2) begin
                            e_dv = 1;
                            if (m_abort) e_ddata = 0;
                            else if (e_rw) e_ddata = mem_data_out;
                        end else if (!m_drop) begin
                            e_iv = 1;
                            e_idata = m_abort ? 32'h0 : mem_data_out;
                        end
                        if (m_abort) e_err = 1;
                        m_owner = 0;
                        m_cool = 1;
                    end
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("mem_enable", 32'(mem_enable), 32'(e_en));
        check_eq("mem_address", mem_address, e_addr);
        check_eq("mem_data_in", mem_data_in, e_wdata);
        check_eq("mem_size", 32'(mem_access_size), 32'(e_size));
        check_eq("mem_rw", 32'(mem_rw), 32'(e_rw));
        check_eq("i_valid", 32'(i_valid), 32'(e_iv));
        check_eq("d_valid", 32'(d_valid), 32'(e_dv));
        check_eq("i_data_out", i_data_out, e_idata);
        check_eq("d_data_out", d_data_out, e_ddata);
        check_eq("bus_err", 32'(bus_err), 32'(e_err));
        check_eq("stall_f", 32'(stall_f), 32'(i_req & ~e_iv));
        check_eq("stall_m", 32'(stall_m), 32'(d_req & ~e_dv));
    endtask

    // Advance to the next falling edge, check, optionally retire completed requests
    task automatic tick(input bit rel);
        @(negedge clock);
        check_all();
        if (rel) begin
            if (d_valid) d_req = 1'b0;
            if (i_valid) i_req = 1'b0;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0; mem_busy = 1'b0;
        tick(0);
        tick(0);
        reset = 1'b0;
    endtask

    task automatic d_read(input logic [31:0] addr, input logic [31:0] rdata);
        d_req = 1'b1; d_rw = 1'b1; d_address = addr; mem_data_out = rdata; mem_busy = 1'b0;
        for (int k = 0; k < 6; k++) tick(1);
    endtask

    int lat, en_cnt, iv_cnt, dv_cnt, dg_cnt, stuck_left;
    bit gq[$];

    initial begin
        reset = 1'b1; i_req = 0; i_address = 0; i_flush = 0; d_req = 0; d_rw = 1;
        d_address = 0; d_data_in = 0; d_access_size = 0; mem_data_out = 0; mem_busy = 0;
        reset_dut();

        // Reset values
        check_eq("rst_mem_rw", 32'(mem_rw), 32'h1);
        check_eq("rst_mem_enable", 32'(mem_enable), 32'h0);
        check_eq("rst_bus_err", 32'(bus_err), 32'h0);

        // Single fetch, minimum latency
        i_req = 1'b1; i_address = 32'h8002_0000; mem_data_out = 32'h27bd_fff8;
        lat = 0; en_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (mem_enable) en_cnt++;
            if (i_valid && lat == 0) begin
                lat = k;
                check_eq("fetch_data", i_data_out, 32'h27bd_fff8);
            end
        end
        check_eq("fetch_latency", 32'(lat), 32'd3);
        check_eq("fetch_enables", 32'(en_cnt), 32'd1);

        // Starvation control: both requesters held
        reset_dut();
        i_req = 1'b1; i_address = 32'h1000; d_req = 1'b1; d_rw = 1'b1; d_address = 32'h2000;
        mem_data_out = 32'h5555_0000;
        gq.delete();
        for (int k = 0; k < 45; k++) begin
            tick(0);
            if (mem_enable) gq.push_back(mem_address == 32'h2000);
        end
        check_eq("order_len", 32'(gq.size() >= 10), 32'h1);
        for (int k = 0; k < 10 && k < gq.size(); k++)
            check_eq($sformatf("order_%0d", k), 32'(gq[k]), 32'((k % 5) != 4));

        // Write after a read: d_data_out keeps the read value
        reset_dut();
        d_read(32'h8002_0000, 32'h1234_5678);
        mem_data_out = 32'ha5a5_a5a5;
        d_req = 1'b1; d_rw = 1'b0; d_address = 32'h8002_0100; d_data_in = 32'hdead_beef; d_access_size = 2'b00;
        en_cnt = 0; dv_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (mem_enable) begin
                en_cnt++;
                check_eq("wr_rw", 32'(mem_rw), 32'h0);
                check_eq("wr_addr", mem_address, 32'h8002_0100);
                check_eq("wr_data", mem_data_in, 32'hdead_beef);
            end
            if (d_valid) dv_cnt++;
        end
        check_eq("wr_enables", 32'(en_cnt), 32'd1);
        check_eq("wr_valids", 32'(dv_cnt), 32'd1);
        check_eq("wr_keep_data", d_data_out, 32'h1234_5678);

        // Flush one cycle after a fetch grant, D waiting behind it
        reset_dut();
        i_req = 1'b1; i_address = 32'h3000; mem_data_out = 32'h7777_0001;
        tick(1);
        check_eq("flush_grant", 32'(mem_enable), 32'h1);
        i_flush = 1'b1; i_req = 1'b0; d_req = 1'b1; d_rw = 1'b1; d_address = 32'h4000;
        tick(1);
        i_flush = 1'b0;
        iv_cnt = 0; dg_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (i_valid) iv_cnt++;
            if (mem_enable && mem_address == 32'h4000) dg_cnt++;
        end
        check_eq("flush_no_ivalid", 32'(iv_cnt), 32'd0);
        check_eq("flush_d_granted", 32'(dg_cnt), 32'd1);

        // Memory stuck busy: timeout abort
        reset_dut();
        d_read(32'h100, 32'h1111_2222);
        d_req = 1'b1; d_rw = 1'b1; d_address = 32'h5000; mem_busy = 1'b1;
        dv_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            tick(1);
            if (d_valid) dv_cnt++;
        end
        check_eq("tmo_valids", 32'(dv_cnt), 32'd1);
        check_eq("tmo_data", d_data_out, 32'h0);
        check_eq("tmo_bus_err", 32'(bus_err), 32'h1);
        for (int k = 0; k < 3; k++) tick(1);
        check_eq("tmo_sticky", 32'(bus_err), 32'h1);

        // Reset in the middle of a busy data access
        reset_dut();
        d_req = 1'b1; d_rw = 1'b1; d_address = 32'h6000; mem_busy = 1'b1;
        for (int k = 0; k < 4; k++) tick(0);
        reset = 1'b1;
        tick(0);
        check_eq("mid_rst_addr", mem_address, 32'h0);
        check_eq("mid_rst_dvalid", 32'(d_valid), 32'h0);
        reset = 1'b0; d_req = 1'b0;
        dv_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick(0);
            if (d_valid) dv_cnt++;
        end
        check_eq("mid_rst_no_valid", 32'(dv_cnt), 32'd0);

        // Randomized traffic
        reset_dut();
        stuck_left = 0;
        for (int k = 0; k < 4000; k++) begin
            tick(1);
            if (!d_req && $urandom_range(2) == 0) begin
                d_req = 1'b1; d_rw = 1'($urandom_range(1)); d_address = $urandom;
                d_data_in = $urandom; d_access_size = 2'($urandom_range(3));
            end else if (d_req && $urandom_range(7) == 0) begin
                d_address = $urandom; d_data_in = $urandom;
            end
            if (!i_req && $urandom_range(2) == 0) begin
                i_req = 1'b1; i_address = $urandom;
            end
            i_flush = ($urandom_range(11) == 0);
            if (i_flush) i_address = $urandom;
            mem_data_out = $urandom;
            if (stuck_left > 0) begin
                stuck_left--;
                mem_busy = 1'b1;
            end else if ($urandom_range(199) == 0) begin
                stuck_left = 20;
                mem_busy = 1'b1;
            end else begin
                mem_busy = ($urandom_range(3) == 0);
            end
            reset = ($urandom_range(499) == 0);
        end
        reset = 1'b0;
        tick(0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
